// File: rtl/ex_alu_wb_pipe.sv
// ex_alu_wb_pipe: post-ALU result pipeline.
// Carries the ALU result and its destination metadata from EX1 (inputs) through the EX2 and EX3
// registers, commits GPR writeback and architectural SR.{S,T} at EX3, provides newest-first
// operand forwarding for Rs/Rt and the forwarded SR.{S,T} that feeds the ALU, and counts
// committed results.
// Ports:
//   clock, reset                      core clock, synchronous active-high reset
//   exHold, exFlush                   stall / kill EX1 input and EX2
//   exInValid/Rn/RnWr/SrWr/Val/SrST   EX1 result and destination metadata
//   fwdRsIdx/fwdRtIdx                 register ids read by decode
//   fwdRsHit/Val, fwdRtHit/Val        forwarded operands (Val=0 on miss)
//   srFwdST                           newest SR {S,T} for the ALU
//   wbValid/wbRn/wbVal                GPR write port
//   srArchST                          architectural SR {S,T}
//   commitCnt                         committed valid results, wraps
module ex_alu_wb_pipe #(
  parameter int unsigned     REG_W    = 7,
  parameter logic [REG_W-1:0] REG_NULL = REG_W'('h3F),
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exHold,
  input  logic             exFlush,
  input  logic             exInValid,
  input  logic [REG_W-1:0] exInRn,
  input  logic             exInRnWr,
  input  logic             exInSrWr,
  input  logic [63:0]      exInVal,
  input  logic [1:0]       exInSrST,
  input  logic [REG_W-1:0] fwdRsIdx,
  input  logic [REG_W-1:0] fwdRtIdx,
  output logic             fwdRsHit,
  output logic [63:0]      fwdRsVal,
  output logic             fwdRtHit,
  output logic [63:0]      fwdRtVal,
  output logic [1:0]       srFwdST,
  output logic             wbValid,
  output logic [REG_W-1:0] wbRn,
  output logic [63:0]      wbVal,
  output logic [1:0]       srArchST,
  output logic [CNT_W-1:0] commitCnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rn;
    logic             rn_wr;
    logic             sr_wr;
    logic [63:0]      val;
    logic [1:0]       sr_st;
  } stage_t;

  stage_t             ex1;
  stage_t             ex2_q, ex3_q;
  logic [1:0]         sr_arch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               commit;

  // A flushed EX1 result is never visible: not forwarded and not captured into EX2.
  always_comb begin
    ex1.valid = exInValid & ~exFlush;
    ex1.rn    = exInRn;
    ex1.rn_wr = exInRnWr;
    ex1.sr_wr = exInSrWr;
    ex1.val   = exInVal;
    ex1.sr_st = exInSrST;
  end

  assign commit = ~exHold & ex3_q.valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      ex2_q     <= '0;
      ex3_q     <= '0;
      sr_arch_q <= 2'b00;
      cnt_q     <= '0;
    end else if (!exHold) begin
      ex2_q       <= ex1;
      ex3_q       <= ex2_q;
      ex3_q.valid <= ex2_q.valid & ~exFlush;
      if (commit) begin
        if (ex3_q.sr_wr) sr_arch_q <= ex3_q.sr_st;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (exFlush) begin
      // Flush kills EX2 even while stalled; EX3 is older than the flush point and survives.
      ex2_q.valid <= 1'b0;
    end
  end

  function automatic logic gpr_hit(stage_t s, logic [REG_W-1:0] idx);
    return s.valid & s.rn_wr & (s.rn == idx) & (idx != REG_NULL);
  endfunction

  always_comb begin
    fwdRsHit = 1'b0;
    fwdRsVal = 64'h0;
    if (gpr_hit(ex1, fwdRsIdx)) begin
      fwdRsHit = 1'b1;
      fwdRsVal = ex1.val;
    end else if (gpr_hit(ex2_q, fwdRsIdx)) begin
      fwdRsHit = 1'b1;
      fwdRsVal = ex2_q.val;
    end else if (gpr_hit(ex3_q, fwdRsIdx)) begin
      fwdRsHit = 1'b1;
      fwdRsVal = ex3_q.val;
    end
  end

  always_comb begin
    fwdRtHit = 1'b0;
    fwdRtVal = 64'h0;
    if (gpr_hit(ex1, fwdRtIdx)) begin
      fwdRtHit = 1'b1;
      fwdRtVal = ex1.val;
    end else if (gpr_hit(ex2_q, fwdRtIdx)) begin
      fwdRtHit = 1'b1;
      fwdRtVal = ex2_q.val;
    end else if (gpr_hit(ex3_q, fwdRtIdx)) begin
      fwdRtHit = 1'b1;
      fwdRtVal = ex3_q.val;
    end
  end

  // EX1 included so back-to-back ADC/SBB chains see the carry without a bubble.
  always_comb begin
    srFwdST = sr_arch_q;
    if (ex1.valid & ex1.sr_wr)          srFwdST = ex1.sr_st;
    else if (ex2_q.valid & ex2_q.sr_wr) srFwdST = ex2_q.sr_st;
    else if (ex3_q.valid & ex3_q.sr_wr) srFwdST = ex3_q.sr_st;
  end

  assign wbValid   = commit & ex3_q.rn_wr & (ex3_q.rn != REG_NULL);
  assign wbRn      = ex3_q.rn;
  assign wbVal     = ex3_q.val;
  assign srArchST  = sr_arch_q;
  assign commitCnt = cnt_q;

endmodule

// File: tb/tb_ex_alu_wb_pipe.sv
// Directed bench for ex_alu_wb_pipe. A second instance with a 2-bit counter shares the stimulus
// to exercise counter wrap.
module tb_ex_alu_wb_pipe;

  logic        clock = 1'b0;
  logic        reset, exHold, exFlush;
  logic        exInValid, exInRnWr, exInSrWr;
  logic [6:0]  exInRn, fwdRsIdx, fwdRtIdx;
  logic [63:0] exInVal;
  logic [1:0]  exInSrST;

  logic        fwdRsHit, fwdRtHit, wbValid;
  logic [63:0] fwdRsVal, fwdRtVal, wbVal;
  logic [1:0]  srFwdST, srArchST;
  logic [6:0]  wbRn;
  logic [31:0] commitCnt;

  logic        s_rs_hit, s_rt_hit, s_wb_valid;
  logic [63:0] s_rs_val, s_rt_val, s_wb_val;
  logic [1:0]  s_sr_fwd, s_sr_arch;
  logic [6:0]  s_wb_rn;
  logic [1:0]  s_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_cnt  = 0;

  always #5 clock = ~clock;

  ex_alu_wb_pipe dut (
    .clock(clock), .reset(reset), .exHold(exHold), .exFlush(exFlush),
    .exInValid(exInValid), .exInRn(exInRn), .exInRnWr(exInRnWr), .exInSrWr(exInSrWr),
    .exInVal(exInVal), .exInSrST(exInSrST), .fwdRsIdx(fwdRsIdx), .fwdRtIdx(fwdRtIdx),
    .fwdRsHit(fwdRsHit), .fwdRsVal(fwdRsVal), .fwdRtHit(fwdRtHit), .fwdRtVal(fwdRtVal),
    .srFwdST(srFwdST), .wbValid(wbValid), .wbRn(wbRn), .wbVal(wbVal),
    .srArchST(srArchST), .commitCnt(commitCnt)
  );

  ex_alu_wb_pipe #(.CNT_W(2)) dut_small (
    .clock(clock), .reset(reset), .exHold(exHold), .exFlush(exFlush),
    .exInValid(exInValid), .exInRn(exInRn), .exInRnWr(exInRnWr), .exInSrWr(exInSrWr),
    .exInVal(exInVal), .exInSrST(exInSrST), .fwdRsIdx(fwdRsIdx), .fwdRtIdx(fwdRtIdx),
    .fwdRsHit(s_rs_hit), .fwdRsVal(s_rs_val), .fwdRtHit(s_rt_hit), .fwdRtVal(s_rt_val),
    .srFwdST(s_sr_fwd), .wbValid(s_wb_valid), .wbRn(s_wb_rn), .wbVal(s_wb_val),
    .srArchST(s_sr_arch), .commitCnt(s_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a further settle delay.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] rn, input logic rnwr, input logic srwr,
                       input logic [63:0] val, input logic [1:0] st);
    exInValid = v;
    exInRn    = rn;
    exInRnWr  = rnwr;
    exInSrWr  = srwr;
    exInVal   = val;
    exInSrST  = st;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, 1'b0, 1'b0, 64'h0, 2'b00);
  endtask

  initial begin
    reset = 1'b1; exHold = 1'b0; exFlush = 1'b0;
    fwdRsIdx = 7'd0; fwdRtIdx = 7'd0;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("reset_wb_valid", 64'(wbValid), 64'd0);
    check_eq("reset_cnt", 64'(commitCnt), 64'd0);
    check_eq("reset_sr_arch", 64'(srArchST), 64'd0);
    check_eq("reset_rs_hit", 64'(fwdRsHit), 64'd0);

    // Single ADD R5 = 0x1234, commits on the third cycle.
    drive(1'b1, 7'd5, 1'b1, 1'b0, 64'h1234, 2'b00);
    tick(); idle();
    check_eq("add_wb_early", 64'(wbValid), 64'd0);
    tick();
    check_eq("add_wb_valid", 64'(wbValid), 64'd1);
    check_eq("add_wb_rn", 64'(wbRn), 64'd5);
    check_eq("add_wb_val", wbVal, 64'h1234);
    tick(); exp_cnt++;
    check_eq("add_cnt", 64'(commitCnt), 64'(exp_cnt));
    check_eq("add_wb_done", 64'(wbValid), 64'd0);

    // Newest-first forwarding of R5.
    fwdRsIdx = 7'd5; fwdRtIdx = 7'd6;
    drive(1'b1, 7'd5, 1'b1, 1'b0, 64'hAAAA, 2'b00);
    check_eq("fwd_ex1_hit", 64'(fwdRsHit), 64'd1);
    check_eq("fwd_ex1_val", fwdRsVal, 64'hAAAA);
    check_eq("fwd_rt_miss_hit", 64'(fwdRtHit), 64'd0);
    check_eq("fwd_rt_miss_val", fwdRtVal, 64'h0);
    tick();
    drive(1'b1, 7'd5, 1'b1, 1'b0, 64'hBBBB, 2'b00);
    check_eq("fwd_ex1_over_ex2", fwdRsVal, 64'hBBBB);
    tick(); idle();
    check_eq("fwd_ex2_hit", 64'(fwdRsHit), 64'd1);
    check_eq("fwd_ex2_over_ex3", fwdRsVal, 64'hBBBB);
    tick();
    check_eq("fwd_ex3_val", fwdRsVal, 64'hBBBB);
    tick(); exp_cnt += 2;
    check_eq("fwd_cnt", 64'(commitCnt), 64'(exp_cnt));
    fwdRsIdx = 7'h3F;
    drive(1'b1, 7'h3F, 1'b1, 1'b0, 64'h5555, 2'b00);
    check_eq("fwd_null_hit", 64'(fwdRsHit), 64'd0);
    tick(); idle(); tick(); tick(); exp_cnt++;
    check_eq("null_cnt", 64'(commitCnt), 64'(exp_cnt));

    // SR: set arch to 2'b10, then CMPEQ 2'b01 forwards in the same cycle.
    drive(1'b1, 7'd0, 1'b0, 1'b1, 64'h0, 2'b10);
    tick(); idle(); tick(); tick(); exp_cnt++;
    check_eq("sr_arch_10", 64'(srArchST), 64'b10);
    check_eq("sr_fwd_arch", 64'(srFwdST), 64'b10);
    drive(1'b1, 7'd0, 1'b0, 1'b1, 64'h0, 2'b01);
    check_eq("sr_fwd_ex1", 64'(srFwdST), 64'b01);
    check_eq("sr_arch_hold", 64'(srArchST), 64'b10);
    tick(); idle();
    check_eq("sr_fwd_ex2", 64'(srFwdST), 64'b01);
    tick(); tick(); exp_cnt++;
    check_eq("sr_arch_01", 64'(srArchST), 64'b01);

    // Hold three cycles with EX3 valid.
    drive(1'b1, 7'd7, 1'b1, 1'b0, 64'h77, 2'b00);
    tick(); idle(); tick();
    exHold = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_wb", 64'(wbValid), 64'd0);
      tick();
      check_eq("hold_cnt", 64'(commitCnt), 64'(exp_cnt));
    end
    exHold = 1'b0; #1;
    check_eq("hold_rel_wb", 64'(wbValid), 64'd1);
    check_eq("hold_rel_rn", 64'(wbRn), 64'd7);
    tick(); exp_cnt++;
    check_eq("hold_rel_cnt", 64'(commitCnt), 64'(exp_cnt));
    check_eq("hold_rel_wb_done", 64'(wbValid), 64'd0);

    // Flush during hold: EX1/EX2 dropped, EX3 still commits.
    drive(1'b1, 7'd8, 1'b1, 1'b0, 64'h88, 2'b00);
    tick();
    drive(1'b1, 7'd9, 1'b1, 1'b0, 64'h99, 2'b00);
    tick();
    drive(1'b1, 7'd10, 1'b1, 1'b0, 64'hAA, 2'b00);
    exHold = 1'b1; exFlush = 1'b1; fwdRsIdx = 7'd10; #1;
    check_eq("flush_ex1_suppr", 64'(fwdRsHit), 64'd0);
    tick();
    exHold = 1'b0; exFlush = 1'b0; fwdRsIdx = 7'd9; idle();
    check_eq("flush_ex2_gone", 64'(fwdRsHit), 64'd0);
    check_eq("flush_ex3_wb", 64'(wbValid), 64'd1);
    check_eq("flush_ex3_rn", 64'(wbRn), 64'd8);
    tick(); exp_cnt++;
    check_eq("flush_cnt", 64'(commitCnt), 64'(exp_cnt));
    check_eq("flush_no_wb", 64'(wbValid), 64'd0);
    tick();
    check_eq("flush_cnt_stable", 64'(commitCnt), 64'(exp_cnt));

    // Counter wrap on the 2-bit instance.
    drive(1'b1, 7'd1, 1'b1, 1'b0, 64'h1, 2'b00);
    tick(); idle(); tick(); tick(); exp_cnt++;
    check_eq("cnt_full", 64'(commitCnt), 64'(exp_cnt));
    check_eq("cnt_wrap", 64'(s_cnt), 64'(exp_cnt % 4));

    // Reset mid-stream, with hold and flush asserted.
    fwdRsIdx = 7'd2;
    drive(1'b1, 7'd2, 1'b1, 1'b1, 64'h22, 2'b11);
    tick();
    drive(1'b1, 7'd3, 1'b1, 1'b0, 64'h33, 2'b00);
    tick();
    exHold = 1'b1; exFlush = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; exHold = 1'b0; exFlush = 1'b0; idle();
    check_eq("rst2_wb", 64'(wbValid), 64'd0);
    check_eq("rst2_cnt", 64'(commitCnt), 64'd0);
    check_eq("rst2_cnt_small", 64'(s_cnt), 64'd0);
    check_eq("rst2_sr_arch", 64'(srArchST), 64'd0);
    check_eq("rst2_sr_fwd", 64'(srFwdST), 64'd0);
    check_eq("rst2_rs_hit", 64'(fwdRsHit), 64'd0);
    tick();
    check_eq("rst2_wb_after", 64'(wbValid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
